// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the front end: data widths, reset PC default,
// squash NOP and the fetch-queue entry layout.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO: head register feeding decode plus one skid register.
// Flush empties it; callers guarantee no push when full without a pop.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t push_entry,
  output logic         valid,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  logic [1:0]   count_q;
  fetch_entry_t head_q;
  fetch_entry_t skid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      head_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      // Pushed entry lands in head when head is empty or being vacated by a
      // lone entry; otherwise it queues behind head in the skid slot.
      if (pop && count_q == 2'd2) begin
        head_q <= skid_q;
        if (push) skid_q <= push_entry;
      end else if (push && (count_q == 2'd0 || pop)) begin
        head_q <= push_entry;
      end else if (push) begin
        skid_q <= push_entry;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid = (count_q != 2'd0);
  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory
// combinationally and hands {instr, pc, pc+4} to decode via valid/ready.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetchEnable,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemInstr,
  output logic        ifValid,
  input  logic        idReady,
  output logic [31:0] ifInstr,
  output logic [31:0] ifPc,
  output logic [31:0] ifPcPlus4
);

  localparam logic [1:0] QFULL = 2'(DEPTH);

  logic [31:0]  pc_q;
  logic [1:0]   count;
  logic         valid;
  logic         pop;
  logic         push;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  assign pop  = valid & idReady;
  assign push = fetchEnable & ~redirectValid & ((count < QFULL) | pop);

  always_comb begin
    push_entry          = '0;
    push_entry.instr    = imemInstr;
    push_entry.pc       = pc_q;
    push_entry.pc_plus4 = pc_q + XLEN'(INSTR_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirectValid) begin
      pc_q <= {redirectTarget[31:2], 2'b00};
    end else if (push) begin
      pc_q <= pc_q + XLEN'(INSTR_BYTES);
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirectValid),
    .push       (push),
    .pop        (pop),
    .push_entry (push_entry),
    .valid      (valid),
    .count      (count),
    .head       (head)
  );

  assign imemAddr  = pc_q;
  assign ifValid   = valid;
  assign ifInstr   = head.instr;
  assign ifPc      = head.pc;
  assign ifPcPlus4 = head.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, randomized run
// against a queue-based reference model, async reset and PC wrap sequences.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        fetchEnable;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr;
  logic        ifValid;
  logic        idReady;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic [31:0] ifPcPlus4;

  logic        rst_n2;
  logic        fe2;
  logic [31:0] imemAddr2;
  logic [31:0] imemInstr2;
  logic        ifValid2;
  logic [31:0] ifInstr2;
  logic [31:0] ifPc2;
  logic [31:0] ifPcPlus42;

  int unsigned checks;
  int unsigned failures;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0011;
      32'h4:   return 32'h0000_0022;
      32'h8:   return 32'h0000_0033;
      default: return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
    endcase
  endfunction

  assign imemInstr  = mem(imemAddr);
  assign imemInstr2 = mem(imemAddr2);

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetchEnable    (fetchEnable),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .imemAddr       (imemAddr),
    .imemInstr      (imemInstr),
    .ifValid        (ifValid),
    .idReady        (idReady),
    .ifInstr        (ifInstr),
    .ifPc           (ifPc),
    .ifPcPlus4      (ifPcPlus4)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n2),
    .fetchEnable    (fe2),
    .redirectValid  (1'b0),
    .redirectTarget (32'h0),
    .imemAddr       (imemAddr2),
    .imemInstr      (imemInstr2),
    .ifValid        (ifValid2),
    .idReady        (1'b1),
    .ifInstr        (ifInstr2),
    .ifPc           (ifPc2),
    .ifPcPlus4      (ifPcPlus42)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        fe;
    logic        rv;
    logic        rdy;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ea;
  } vec_t;

  function automatic vec_t mkv(input logic fe, input logic rv, input logic rdy,
                               input logic [31:0] tgt, input logic ev,
                               input logic [31:0] ei, input logic [31:0] ep,
                               input logic [31:0] ea);
    vec_t v;
    v.fe = fe; v.rv = rv; v.rdy = rdy; v.tgt = tgt;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mpc;

  task automatic model_reset(input logic [31:0] rpc);
    mq.delete();
    mpc = rpc;
  endtask

  // Reference step: decide pop/push from pre-edge state, clock, then update.
  task automatic model_cycle(input logic fe, input logic rv, input logic rdy,
                             input logic [31:0] tgt);
    bit    pop;
    bit    push;
    ment_t e;
    pop  = (mq.size() > 0) && rdy;
    push = fe && !rv && ((mq.size() < 2) || pop);
    chk("imemAddr_pre", imemAddr, mpc);
    @(posedge clk);
    #1;
    if (rv) begin
      mq.delete();
      mpc = {tgt[31:2], 2'b00};
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        e.instr = mem(mpc);
        e.pc    = mpc;
        mq.push_back(e);
        mpc = mpc + 32'd4;
      end
    end
    chk("rand_ifValid", {31'b0, ifValid}, {31'b0, mq.size() > 0});
    chk("rand_imemAddr", imemAddr, mpc);
    if (mq.size() > 0) begin
      chk("rand_ifInstr", ifInstr, mq[0].instr);
      chk("rand_ifPc", ifPc, mq[0].pc);
      chk("rand_ifPcPlus4", ifPcPlus4, mq[0].pc + 32'd4);
    end
  endtask

  vec_t tv[12];

  initial begin
    logic        fe;
    logic        rv;
    logic        rdy;
    logic [31:0] tgt;
    checks = 0;
    failures = 0;

    tv[0]  = mkv(1, 0, 0, 0,      1, 32'h11,       32'h0,   32'h4);
    tv[1]  = mkv(1, 0, 0, 0,      1, 32'h11,       32'h0,   32'h8);
    tv[2]  = mkv(1, 0, 0, 0,      1, 32'h11,       32'h0,   32'h8);
    tv[3]  = mkv(1, 0, 0, 0,      1, 32'h11,       32'h0,   32'h8);
    tv[4]  = mkv(1, 0, 1, 0,      1, 32'h22,       32'h4,   32'hC);
    tv[5]  = mkv(1, 0, 1, 0,      1, 32'h33,       32'h8,   32'h10);
    tv[6]  = mkv(1, 1, 0, 32'h103, 0, 0,           0,       32'h100);
    tv[7]  = mkv(1, 0, 0, 0,      1, mem(32'h100), 32'h100, 32'h104);
    tv[8]  = mkv(1, 0, 0, 0,      1, mem(32'h100), 32'h100, 32'h108);
    tv[9]  = mkv(0, 0, 1, 0,      1, mem(32'h104), 32'h104, 32'h108);
    tv[10] = mkv(0, 0, 1, 0,      0, 0,            0,       32'h108);
    tv[11] = mkv(0, 0, 1, 0,      0, 0,            0,       32'h108);

    rst_n = 1'b0; rst_n2 = 1'b0; fe2 = 1'b0;
    fetchEnable = 1'b1; redirectValid = 1'b0; redirectTarget = '0; idReady = 1'b0;
    #12;
    chk("rst_ifValid", {31'b0, ifValid}, 32'h0);
    chk("rst_ifInstr", ifInstr, 32'h0);
    chk("rst_ifPc", ifPc, 32'h0);
    chk("rst_ifPcPlus4", ifPcPlus4, 32'h0);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_wrap_imemAddr", imemAddr2, 32'hFFFF_FFF8);

    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      fetchEnable = tv[i].fe; redirectValid = tv[i].rv;
      redirectTarget = tv[i].tgt; idReady = tv[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_ifValid", i), {31'b0, ifValid}, {31'b0, tv[i].ev});
      chk($sformatf("vec%0d_imemAddr", i), imemAddr, tv[i].ea);
      if (tv[i].ev) begin
        chk($sformatf("vec%0d_ifInstr", i), ifInstr, tv[i].ei);
        chk($sformatf("vec%0d_ifPc", i), ifPc, tv[i].ep);
        chk($sformatf("vec%0d_ifPcPlus4", i), ifPcPlus4, tv[i].ep + 32'd4);
      end
    end

    // Randomized run against the reference model.
    rst_n = 1'b0; fetchEnable = 1'b0; redirectValid = 1'b0; idReady = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset(32'h0);
    for (int i = 0; i < 2000; i++) begin
      fe  = ($urandom % 8) != 0;
      rv  = ($urandom % 16) == 0;
      rdy = ($urandom % 3) != 0;
      tgt = (($urandom % 4) == 0) ? 32'hFFFF_FFF1 : $urandom;
      fetchEnable = fe; redirectValid = rv; redirectTarget = tgt; idReady = rdy;
      model_cycle(fe, rv, rdy, tgt);
    end

    // Async reset between edges with a full queue.
    fetchEnable = 1'b1; redirectValid = 1'b0; idReady = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_async_ifValid", {31'b0, ifValid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_ifValid", {31'b0, ifValid}, 32'h0);
    chk("async_imemAddr", imemAddr, 32'h0);
    chk("async_ifPc", ifPc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // PC wrap on the second instance.
    @(posedge clk); #1;
    rst_n2 = 1'b1; fe2 = 1'b1;
    @(posedge clk); #1;
    chk("wrap0_ifValid", {31'b0, ifValid2}, 32'h1);
    chk("wrap0_ifPc", ifPc2, 32'hFFFF_FFF8);
    chk("wrap0_ifInstr", ifInstr2, mem(32'hFFFF_FFF8));
    chk("wrap0_imemAddr", imemAddr2, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    chk("wrap1_ifPc", ifPc2, 32'hFFFF_FFFC);
    chk("wrap1_ifPcPlus4", ifPcPlus42, 32'h0);
    chk("wrap1_imemAddr", imemAddr2, 32'h0);
    @(posedge clk); #1;
    chk("wrap2_ifPc", ifPc2, 32'h0);
    chk("wrap2_ifInstr", ifInstr2, 32'h11);
    chk("wrap2_ifPcPlus4", ifPcPlus42, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
